mem_access_unit: RTL and testbench

- Initiator side of the data RAM interface; sits in the MEM stage between the pipeline and the data RAM.
- Accepts one load/store request at a time and drives the RAM's chip-select, write-enable, word address and write data.
- Extracts byte/halfword load results from the RAM's 32-bit big-endian read word.
- Implements byte/halfword stores as read-modify-write, because the RAM only writes whole 4-byte words.

---
 rtl/mem_access_unit.sv | 168 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage initiator for a 32-bit big-endian data RAM.
// Loads are a single read; SW is a single write; SB/SH are read-modify-write.
// Optional feature macro: MEM_ACCESS_ALIGN_CHECK_EN (flags misaligned word/halfword ops).
module mem_access_unit #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [3:0]        op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] load_data,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] OP_LB  = 4'd0;
    localparam logic [3:0] OP_LH  = 4'd1;
    localparam logic [3:0] OP_LW  = 4'd2;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd8;
    localparam logic [3:0] OP_SH  = 4'd9;
    localparam logic [3:0] OP_SW  = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCESS = 3'd1,
        S_RMW_RD = 3'd2,
        S_RMW_WR = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t              state;
    logic [3:0]          op_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   st_q;
    logic [DATA_W-1:0]   rd_q;
    logic                err_q;
    logic                bad_align;
    logic                req_bad;

    function automatic logic op_legal(input logic [3:0] o);
        case (o)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: op_legal = 1'b1;
            default: op_legal = 1'b0;
        endcase
    endfunction

    // Pick the big-endian lane addressed by off and extend it to a full word.
    function automatic logic [DATA_W-1:0] load_extract(input logic [3:0] o, input logic [1:0] off,
                                                       input logic [DATA_W-1:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        h = off[1] ? w[15:0] : w[31:16];
        case (o)
            OP_LB:   load_extract = {{(DATA_W-8){b[7]}}, b};
            OP_LBU:  load_extract = {{(DATA_W-8){1'b0}}, b};
            OP_LH:   load_extract = {{(DATA_W-16){h[15]}}, h};
            OP_LHU:  load_extract = {{(DATA_W-16){1'b0}}, h};
            default: load_extract = w;
        endcase
    endfunction

    // Replace the addressed byte/halfword lane of the word read back from RAM.
    function automatic logic [DATA_W-1:0] store_merge(input logic [3:0] o, input logic [1:0] off,
                                                      input logic [DATA_W-1:0] w, input logic [15:0] d);
        store_merge = w;
        if (o == OP_SH) begin
            if (off[1]) store_merge[15:0]  = d;
            else        store_merge[31:16] = d;
        end else begin
            case (off)
                2'd0:    store_merge[31:24] = d[7:0];
                2'd1:    store_merge[23:16] = d[7:0];
                2'd2:    store_merge[15:8]  = d[7:0];
                default: store_merge[7:0]  = d[7:0];
            endcase
        end
    endfunction

    // Alignment fault detection on the incoming request.
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    always_comb begin
        case (op)
            OP_LW, OP_SW:         bad_align = (addr[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH: bad_align = addr[0];
            default:              bad_align = 1'b0;
        endcase
    end
`else
    assign bad_align = 1'b0;
`endif

    assign req_bad = !op_legal(op) || bad_align;

    // Status and RAM strobes decode straight from state so reset drops them at once.
    assign busy     = (state == S_ACCESS) || (state == S_RMW_RD) || (state == S_RMW_WR);
    assign done     = (state == S_DONE);
    assign err      = done && err_q;
    assign mem_ce   = busy;
    assign mem_we   = ((state == S_ACCESS) && (op_q == OP_SW)) || (state == S_RMW_WR);
    assign mem_addr = mem_ce ? {addr_q[ADDR_W-1:2], 2'b00} : '0;

    // Write data: raw store word for SW, merged word during the RMW write cycle.
    always_comb begin
        mem_wdata = '0;
        if ((state == S_ACCESS) && (op_q == OP_SW)) begin
            mem_wdata = st_q;
        end else if (state == S_RMW_WR) begin
            mem_wdata = store_merge(op_q, addr_q[1:0], rd_q, st_q[15:0]);
        end
    end

    // Access sequencer with request latches, RMW read buffer and load result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            op_q      <= '0;
            addr_q    <= '0;
            st_q      <= '0;
            rd_q      <= '0;
            err_q     <= 1'b0;
            load_data <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (req) begin
                        op_q   <= op;
                        addr_q <= addr;
                        st_q   <= st_data;
                        err_q  <= req_bad;
                        if (req_bad)                           state <= S_DONE;
                        else if ((op == OP_SB) || (op == OP_SH)) state <= S_RMW_RD;
                        else                                   state <= S_ACCESS;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_ACCESS: begin
                    if (!op_q[3]) load_data <= load_extract(op_q, addr_q[1:0], mem_rdata);
                    state <= S_DONE;
                end
                S_RMW_RD: begin
                    rd_q  <= mem_rdata;
                    state <= S_RMW_WR;
                end
                S_RMW_WR: state <= S_DONE;
                default:  state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: byte-array reference model, word RAM model.
module tb_mem_access_unit;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int NWORDS = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              req;
    logic [3:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] st_data;
    logic              busy;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] load_data;
    logic              mem_ce;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              ram_fill;
    logic [31:0]       ram [NWORDS];
    logic [7:0]        ref_mem [NWORDS*4];
    logic [31:0]       ref_last_load;
    logic [3:0]        legal_ops [8] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10};

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic        err;
        logic [31:0] ld;
        int          lat;
        int          cyc;
        logic [3:0]  op;
        logic [31:0] addr;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mem_access_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .addr(addr), .st_data(st_data),
        .busy(busy), .done(done), .err(err), .load_data(load_data),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] init_word(input int w);
        return (32'(w) * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    // Word-wide RAM: writes on the clock edge, combinational read, poison when unselected.
    always @(posedge clk) begin
        if (ram_fill) begin
            for (int w = 0; w < NWORDS; w++) ram[w] <= init_word(w);
        end else if (mem_ce && mem_we) begin
            ram[mem_addr[7:2]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem_ce ? ram[mem_addr[7:2]] : 32'hDEAD_BEEF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: byte-addressed memory, big-endian assembly, plain arithmetic.
    task automatic model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] d, output exp_t e);
        logic        legal;
        logic        bad;
        int          size;
        int          base;
        logic [63:0] v;
        legal = (o inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10});
        case (o)
            4'd0, 4'd4, 4'd8: size = 1;
            4'd1, 4'd5, 4'd9: size = 2;
            default:          size = 4;
        endcase
        bad = 1'b0;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        if ((size > 1) && ((int'(a) % size) != 0)) bad = 1'b1;
`endif
        e.op   = o;
        e.addr = a;
        e.cyc  = 0;
        if (!legal || bad) begin
            e.err = 1'b1;
            e.lat = 1;
            e.ld  = ref_last_load;
            return;
        end
        e.err = 1'b0;
        base  = int'(a) - (int'(a) % size);
        if (o < 4'd8) begin
            v = 64'd0;
            for (int i = 0; i < size; i++) v = (v << 8) | 64'(ref_mem[base + i]);
            if (((o == 4'd0) || (o == 4'd1)) && v[8*size-1]) v = v - (64'd1 << (8*size));
            ref_last_load = v[31:0];
            e.lat = 2;
        end else begin
            for (int i = 0; i < size; i++) ref_mem[base + i] = 8'(d >> (8*(size-1-i)));
            e.lat = (size == 4) ? 2 : 3;
        end
        e.ld = ref_last_load;
    endtask

    // Present one request as soon as the unit is not busy; junk is driven while it is busy.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        int   guard;
        guard = 0;
        @(negedge clk);
        while (busy && (guard < 20)) begin
            req     = 1'($urandom);
            op      = 4'($urandom);
            addr    = $urandom;
            st_data = $urandom;
            guard++;
            @(negedge clk);
        end
        if (busy) begin
            check("issue_wait_busy", 32'(busy), 32'd0);
        end else begin
            req     = 1'b1;
            op      = o;
            addr    = a;
            st_data = d;
            model(o, a, d, e);
            e.cyc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req = 1'b0;
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        @(negedge clk);
        req = 1'b0;
        while (((sb.size() != 0) || busy) && (guard < 30)) begin
            @(negedge clk);
            guard++;
        end
        check("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: strobe sanity every cycle, scoreboard pop on each done pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("ce_matches_busy", 32'(mem_ce), 32'(busy));
                check("we_without_ce", 32'(mem_we & ~mem_ce), 32'd0);
                if (mem_ce) check("mem_addr_word", mem_addr & 32'hFFFF_FF03, 32'd0);
                if (done) begin
                    if (sb.size() == 0) begin
                        check("spurious_done", 32'(done), 32'd0);
                    end else begin
                        mon_e = sb.pop_front();
                        check("err", 32'(err), 32'(mon_e.err));
                        check("load_data", load_data, mon_e.ld);
                        check("latency", 32'(cyc - mon_e.cyc), 32'(mon_e.lat));
                    end
                end else begin
                    check("err_without_done", 32'(err), 32'd0);
                end
            end
        end
    end

    initial begin
        #400000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] saved;
        logic [3:0]  o;
        int          guard;
        rst = 1'b1; req = 1'b0; op = '0; addr = '0; st_data = '0;
        ram_fill = 1'b1;
        ref_last_load = '0;
        for (int w = 0; w < NWORDS; w++)
            for (int i = 0; i < 4; i++) ref_mem[4*w + i] = 8'(init_word(w) >> (24 - 8*i));
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_load_data", load_data, 32'd0);
        check("rst_mem_ce", 32'(mem_ce), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        ram_fill = 1'b0;
        rst = 1'b0;

        // Directed sequence, issued back-to-back with req held high.
        issue(4'd10, 32'h10, 32'h1122_3344);
        issue(4'd2,  32'h10, 32'h0);
        issue(4'd8,  32'h12, 32'h0000_00AA);
        issue(4'd2,  32'h10, 32'h0);
        issue(4'd10, 32'h20, 32'h80FF_7F01);
        issue(4'd0,  32'h20, 32'h0);
        issue(4'd4,  32'h20, 32'h0);
        issue(4'd1,  32'h22, 32'h0);
        issue(4'd5,  32'h20, 32'h0);
        issue(4'd1,  32'h20, 32'h0);
        issue(4'd2,  32'h11, 32'h0);
        issue(4'd3,  32'h30, 32'h0);
        issue(4'd10, 32'h30, $urandom);
        issue(4'd2,  32'h30, 32'h0);
        drain();
        check("word_0x10", ram[4], 32'h1122_AA44);
        check("word_0x20", ram[8], 32'h80FF_7F01);

        // Abort an SH in its write cycle: no write, no done, strobes drop at once.
        @(negedge clk);
        req = 1'b1; op = 4'd9; addr = 32'h40; st_data = 32'h0000_BEEF;
        @(negedge clk);
        req = 1'b0;
        guard = 0;
        while (!mem_we && (guard < 5)) begin
            @(negedge clk);
            guard++;
        end
        check("rmw_wr_reached", 32'(mem_we), 32'd1);
        saved = ram[16];
        rst = 1'b1;
        #1;
        check("abort_mem_ce", 32'(mem_ce), 32'd0);
        check("abort_mem_we", 32'(mem_we), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        ref_last_load = '0;
        @(posedge clk);
        #1;
        check("abort_word_0x40", ram[16], saved);
        check("abort_load_data", load_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        issue(4'd2, 32'h40, 32'h0);

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) o = 4'($urandom);
            else                            o = legal_ops[$urandom_range(0, 7)];
            issue(o, $urandom_range(0, 255), $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        drain();

        for (int w = 0; w < NWORDS; w++)
            check("ram_word", ram[w], {ref_mem[4*w], ref_mem[4*w+1], ref_mem[4*w+2], ref_mem[4*w+3]});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
